conv_frame_writer: RTL and testbench
====================================

// Module: conv_frame_writer
// PURPOSE
//  Output-side partner of conv: drains conv results via resultValid/out_accepting_values, converts each
//  signed 32-bit sum to an 8-bit grey pixel (abs + saturate) and writes 24-bit pixels {3{pix}} into an output FIFO.
//  Adds a PAD_PIXEL border so a valid-only (N-2)x(N-2) result grid becomes a full NxN frame (3x3 window, stride 1).
//  Sits between conv and the output FIFO / frame sink; one frame per start pulse.
// PARAMETERS
//  RESULT_WIDTH  32        width of conv result (two's complement)
//  PIX_WIDTH     8         output grey channel width
//  DIM_WIDTH     8         width of input_dim
//  PAD_PIXEL     24'h0000FF border pixel written to out_din ([7:0] = first byte in file order)
// PORTS
//  clock                 in   1             rising-edge clock
//  reset                 in   1             asynchronous, active-high
//  start                 in   1             1-cycle pulse; begins a frame when idle
//  input_dim             in   DIM_WIDTH     frame side N; sampled on accepted start; legal 4..255
//  result                in   RESULT_WIDTH  signed conv output
//  resultValid           in   1             result valid; conv holds result until accepted
//  out_accepting_values  out  1             ready back to conv; handshake = resultValid & out_accepting_values
//  out_din               out  3*PIX_WIDTH   pixel to FIFO
//  out_wr_en             out  1             FIFO write strobe; never high while out_full
//  out_full              in   1             FIFO full
//  busy                  out  1             frame in progress
//  done                  out  1             1-cycle pulse after last pixel of frame written
// BEHAVIOUR
//  Reset: state IDLE, counters 0, hold_valid 0; out_wr_en, out_accepting_values, busy, done = 0; out_din = 0.
//  FSM: IDLE -> TOP on start (N latched) | TOP: N+1 pads (top row + left of row 1) -> ROW
//   ROW: N-2 interior pixels from conv -> EDGE if rows left, else BOTTOM | EDGE: 2 pads (right + next left) -> ROW
//   BOTTOM: N+1 pads (right of last row + bottom row) -> DONE | DONE: done=1 for one cycle -> IDLE.
//  Total writes per frame = N*N exactly; column/row counters wrap at N-2 / N-2.
//  Pad write: when !out_full and hold_valid=0, one pad per cycle; out_full stalls without loss.
//  Interior: 1-entry hold register. out_accepting_values = (state==ROW) & (remaining-in-row>0) & (!hold_valid | !out_full)
//   (combinational through out_full). Accepted result converted and loaded into hold next edge;
//   hold written when !out_full; load and write in same cycle sustain 1 pixel/clock.
//  Conversion: mag = |result| (most-negative value -> saturates); pix = (mag > 2^PIX_WIDTH-1) ? all-ones : mag.
//  Latency: accepted result -> out_wr_en 1 cycle when FIFO not full.
//  Boundaries: start while busy ignored; resultValid outside ROW or after row count reached is not accepted
//   (out_accepting_values=0); done and start same cycle -> new start ignored (start honoured only in IDLE);
//   reset mid-frame aborts immediately, hold content discarded, no done.
//  input_dim < 4 on start: frame rejected, done pulses next cycle, nothing written.
// CONFIGURATION
//  CONV_OUT_RELU_EN defined: conversion is ReLU — result<0 -> 0, else saturate to 8 bits (no abs).
//  Undefined: abs + saturate as above. Geometry and handshake identical in both builds.
// STRUCTURE
//  conv_pkg: fw_state_t enum, pixel_t (PIX_WIDTH), rgb_t (3*PIX_WIDTH), PAD_PIXEL default, MIN_DIM=4.
//  Sub-module conv_result_to_pixel: combinational abs/ReLU + saturate, macro-sensitive; FSM/counters here.
// TESTING
//  N=4, out_full=0, 4 results {5,-7,300,-2147483648} back-to-back -> 16 writes: 5 pads, 05,07, 2 pads, FF,FF, 5 pads; done once.
//  N=224, resultValid always 1, random result -> 50176 writes, 49284 accepts, first 225 = PAD_PIXEL, 1 px/clk when not full.
//  out_full toggled 50% random during ROW -> no pixel lost/duplicated; out_wr_en never with out_full; order preserved.
//  resultValid held with extra results after frame -> out_accepting_values stays 0 from BOTTOM to next start.
//  reset asserted mid-ROW -> outputs 0 same cycle; fresh start N=4 produces correct 16-pixel frame.
//  CONV_OUT_RELU_EN build: results {-5,12,256,-1} -> pixels 00,0C,FF,00.

Source files
------------

// File: rtl/conv_frame_writer_pkg.sv
// Shared types and constants for conv_frame_writer: FSM state encoding, pixel types, border pixel.
// The build macro CONV_OUT_RELU_EN (see conv_frame_writer_result_to_pixel) does not change anything here.
package conv_frame_writer_pkg;

    localparam int RESULT_WIDTH = 32;
    localparam int PIX_WIDTH    = 8;
    localparam int DIM_WIDTH    = 8;

    typedef logic [PIX_WIDTH-1:0]   pixel_t;
    typedef logic [3*PIX_WIDTH-1:0] rgb_t;

    typedef enum logic [2:0] {
        FW_IDLE   = 3'd0,
        FW_TOP    = 3'd1,
        FW_ROW    = 3'd2,
        FW_EDGE   = 3'd3,
        FW_BOTTOM = 3'd4,
        FW_DONE   = 3'd5
    } fw_state_t;

    localparam rgb_t                   PAD_PIXEL = 24'h0000FF;
    localparam logic [DIM_WIDTH-1:0]   MIN_DIM   = DIM_WIDTH'(4);
    localparam logic [RESULT_WIDTH-1:0] PIX_MAX  = RESULT_WIDTH'((1 << PIX_WIDTH) - 1);

endpackage

// File: rtl/conv_frame_writer_if.sv
// Result handshake from conv plus write port into the output FIFO.
// master = the frame writer, slave = conv/FIFO side.
interface conv_frame_writer_if;
    import conv_frame_writer_pkg::*;

    logic signed [RESULT_WIDTH-1:0] result;
    logic                           resultValid;
    logic                           out_accepting_values;
    rgb_t                           out_din;
    logic                           out_wr_en;
    logic                           out_full;

    modport master (
        input  result, resultValid, out_full,
        output out_accepting_values, out_din, out_wr_en
    );

    modport slave (
        output result, resultValid, out_full,
        input  out_accepting_values, out_din, out_wr_en
    );

endinterface

// File: rtl/conv_frame_writer_result_to_pixel.sv
// Combinational conv result -> grey pixel. Default: |result| saturated to PIX_WIDTH bits.
// With CONV_OUT_RELU_EN defined: negative results clamp to 0, positives saturate.
module conv_frame_writer_result_to_pixel
    import conv_frame_writer_pkg::*;
(
    input  logic signed [RESULT_WIDTH-1:0] result,
    output pixel_t                         pix
);

    logic [RESULT_WIDTH-1:0] mag;

    always_comb begin
`ifdef CONV_OUT_RELU_EN
        mag = result[RESULT_WIDTH-1] ? '0 : result;
`else
        // the most negative value negates to itself, which as unsigned still saturates
        mag = result[RESULT_WIDTH-1] ? -result : result;
`endif
        pix = (mag > PIX_MAX) ? '1 : mag[PIX_WIDTH-1:0];
    end

endmodule

// File: rtl/conv_frame_writer.sv
// Turns the (N-2)x(N-2) conv result stream into a padded NxN frame written to the output FIFO.
// Pixel conversion follows the CONV_OUT_RELU_EN build macro (abs+saturate when undefined).
//
//  state  | meaning
//  IDLE   | waiting for start
//  TOP    | N+1 pads: top row plus left border of first interior row
//  ROW    | accepting N-2 interior results through the hold register
//  EDGE   | 2 pads: right border of this row, left border of the next
//  BOTTOM | N+1 pads: right border of last row plus bottom row
//  DONE   | one-cycle done pulse
module conv_frame_writer
    import conv_frame_writer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DIM_WIDTH-1:0]   input_dim,
    output logic                   busy,
    output logic                   done,
    conv_frame_writer_if.master    bus
);

    fw_state_t            state_q, state_d;
    logic [DIM_WIDTH-1:0] dim_q, dim_d;
    logic [DIM_WIDTH-1:0] pad_cnt_q, pad_cnt_d;
    logic [DIM_WIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [DIM_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic                 hold_valid_q, hold_valid_d;
    pixel_t               hold_pix_q, hold_pix_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    pixel_t conv_pix;
    logic   pad_phase;
    logic   pad_wr;
    logic   hold_wr;
    logic   accept;

    conv_frame_writer_result_to_pixel u_to_pixel (
        .result (bus.result),
        .pix    (conv_pix)
    );

    // Pads wait for the hold register to drain so raster order is kept across ROW exits.
    assign pad_phase = (state_q == FW_TOP) || (state_q == FW_EDGE) || (state_q == FW_BOTTOM);
    assign hold_wr   = hold_valid_q && !bus.out_full;
    assign pad_wr    = pad_phase && !hold_valid_q && !bus.out_full;
    assign bus.out_accepting_values = (state_q == FW_ROW) && (col_cnt_q != '0)
                                      && (!hold_valid_q || !bus.out_full);
    assign accept        = bus.resultValid && bus.out_accepting_values;
    assign bus.out_wr_en = hold_wr || pad_wr;
    assign bus.out_din   = hold_valid_q ? {3{hold_pix_q}} : (pad_phase ? PAD_PIXEL : '0);
    assign busy          = busy_q;
    assign done          = done_q;

    always_comb begin
        state_d      = state_q;
        dim_d        = dim_q;
        pad_cnt_d    = pad_cnt_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        hold_valid_d = hold_valid_q;
        hold_pix_d   = hold_pix_q;
        done_d       = 1'b0;

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_pix_d   = conv_pix;
        end else if (hold_wr) begin
            hold_valid_d = 1'b0;
        end

        case (state_q)
            FW_IDLE: begin
                if (start) begin
                    if (input_dim < MIN_DIM) begin
                        state_d = FW_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = FW_TOP;
                        dim_d     = input_dim;
                        pad_cnt_d = input_dim;
                        row_cnt_d = input_dim - DIM_WIDTH'(2);
                    end
                end
            end
            FW_TOP, FW_EDGE: begin
                if (pad_wr) begin
                    if (pad_cnt_q == '0) begin
                        state_d   = FW_ROW;
                        col_cnt_d = dim_q - DIM_WIDTH'(2);
                    end else begin
                        pad_cnt_d = pad_cnt_q - DIM_WIDTH'(1);
                    end
                end
            end
            FW_ROW: begin
                if (accept) begin
                    col_cnt_d = col_cnt_q - DIM_WIDTH'(1);
                    if (col_cnt_q == DIM_WIDTH'(1)) begin
                        row_cnt_d = row_cnt_q - DIM_WIDTH'(1);
                        if (row_cnt_q == DIM_WIDTH'(1)) begin
                            state_d   = FW_BOTTOM;
                            pad_cnt_d = dim_q;
                        end else begin
                            state_d   = FW_EDGE;
                            pad_cnt_d = DIM_WIDTH'(1);
                        end
                    end
                end
            end
            FW_BOTTOM: begin
                if (pad_wr) begin
                    if (pad_cnt_q == '0) begin
                        state_d = FW_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pad_cnt_d = pad_cnt_q - DIM_WIDTH'(1);
                    end
                end
            end
            FW_DONE: state_d = FW_IDLE;
            default: state_d = FW_IDLE;
        endcase

        busy_d = state_d inside {FW_TOP, FW_ROW, FW_EDGE, FW_BOTTOM};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FW_IDLE;
            dim_q        <= '0;
            pad_cnt_q    <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_pix_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dim_q        <= dim_d;
            pad_cnt_q    <= pad_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_pix_q   <= hold_pix_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Bench for conv_frame_writer: raster-order frame model (border = pad, interior = converted result)
// checked against every FIFO write, plus hand-computed pixel literals. Honours CONV_OUT_RELU_EN.
module tb_conv_frame_writer;
    import conv_frame_writer_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [DIM_WIDTH-1:0] input_dim;
    logic                 busy;
    logic                 done;

    conv_frame_writer_if bus ();

    conv_frame_writer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .input_dim (input_dim),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   res_q[$];
    int   res_idx     = 0;
    bit   hs          = 1'b0;
    bit   valid_en    = 1'b0;
    bit   full_rand   = 1'b0;
    bit   check_en    = 1'b0;
    rgb_t exp_q[$];
    rgb_t cap_q[$];
    int   exp_accepts = 0;
    int   done_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic rgb_t model_pix(input int r);
        longint     v;
        logic [7:0] p;
        v = longint'(r);
`ifdef CONV_OUT_RELU_EN
        if (v < 0) v = 0;
`else
        if (v < 0) v = -v;
`endif
        if (v > 255) v = 255;
        p = 8'(v);
        return {p, p, p};
    endfunction

    function automatic void build_frame(input int n);
        int k = 0;
        exp_q.delete();
        exp_accepts = 0;
        if (n < 4) return;
        exp_accepts = (n - 2) * (n - 2);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (r == 0 || r == n - 1 || c == 0 || c == n - 1) exp_q.push_back(PAD_PIXEL);
                else exp_q.push_back(model_pix(res_q[k++]));
    endfunction

    // conv side: results advance only after a handshake seen before the rising edge
    always begin
        @(negedge clock);
        if (hs) res_idx++;
        bus.resultValid = valid_en;
        bus.result      = (res_idx < res_q.size()) ? res_q[res_idx] : int'($urandom);
        bus.out_full    = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        hs = bus.resultValid && bus.out_accepting_values;
    end

    always begin
        @(negedge clock);
        #2;
        if (check_en && !reset) begin
            if (bus.out_wr_en) begin
                check("wr_en_while_full", bus.out_full, 1'b0);
                cap_q.push_back(bus.out_din);
                check("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("pixel", bus.out_din, exp_q.pop_front());
            end
            if (bus.out_accepting_values) begin
                check("accept_only_busy", busy, 1'b1);
                check("accept_within_quota", res_idx < exp_accepts, 1'b1);
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_frame(input int n, input int budget, input int inj, input bit start_on_done);
        int cyc  = 0;
        bit stop = 1'b0;
        build_frame(n);
        cap_q.delete();
        done_cnt = 0;
        res_idx  = 0;
        hs       = 1'b0;
        start     = 1'b1;
        input_dim = DIM_WIDTH'(n);
        while (!stop && cyc < budget) begin
            @(negedge clock);
            #3;
            cyc++;
            start = 1'b0;
            if (cyc == inj) begin
                start     = 1'b1;
                input_dim = 8'd4;
            end
            if (done) begin
                stop = 1'b1;
                if (start_on_done) begin
                    start     = 1'b1;
                    input_dim = 8'd4;
                end
            end
        end
        @(negedge clock);
        #3;
        start = 1'b0;
        repeat (6) @(negedge clock);
        #3;
        check("done_pulses", done_cnt, 1);
        check("write_count", cap_q.size(), (n >= 4) ? n * n : 0);
        check("accept_count", res_idx, exp_accepts);
        check("busy_after_frame", busy, 1'b0);
    endtask

    task automatic check_lits(input string tag, input rgb_t a, input rgb_t b, input rgb_t c, input rgb_t d);
        if (cap_q.size() > 15) begin
            check({tag, "_pad0"}, cap_q[0], 24'h0000FF);
            check({tag, "_px5"}, cap_q[5], a);
            check({tag, "_px6"}, cap_q[6], b);
            check({tag, "_pad7"}, cap_q[7], 24'h0000FF);
            check({tag, "_px9"}, cap_q[9], c);
            check({tag, "_px10"}, cap_q[10], d);
            check({tag, "_pad15"}, cap_q[15], 24'h0000FF);
        end else begin
            check({tag, "_frame_size"}, cap_q.size(), 16);
        end
    endtask

    initial begin
        int cyc;
        int pads;
        reset            = 1'b1;
        start            = 1'b0;
        input_dim        = '0;
        bus.result       = '0;
        bus.resultValid  = 1'b0;
        bus.out_full     = 1'b0;

        repeat (3) @(negedge clock);
        #3;
        check("rst_wr_en", bus.out_wr_en, 1'b0);
        check("rst_accepting", bus.out_accepting_values, 1'b0);
        check("rst_din", bus.out_din, 24'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        #3;
        check("idle_busy", busy, 1'b0);
        check("idle_accepting", bus.out_accepting_values, 1'b0);
        check_en = 1'b1;
        valid_en = 1'b1;

        check("model_pin_min", model_pix(int'(32'h80000000)), 24'hFFFFFF);
`ifdef CONV_OUT_RELU_EN
        check("model_pin_neg", model_pix(-7), 24'h000000);
`else
        check("model_pin_neg", model_pix(-7), 24'h070707);
`endif

        // N=4, back-to-back results, FIFO never full
        res_q = '{5, -7, 300, int'(32'h80000000)};
        run_frame(4, 200, 0, 1'b0);
`ifdef CONV_OUT_RELU_EN
        check_lits("f4a", 24'h050505, 24'h000000, 24'hFFFFFF, 24'h000000);
`else
        check_lits("f4a", 24'h050505, 24'h070707, 24'hFFFFFF, 24'hFFFFFF);
`endif

        // start on the done cycle must be ignored
        res_q = '{-5, 12, 256, -1};
        run_frame(4, 200, 0, 1'b1);
`ifdef CONV_OUT_RELU_EN
        check_lits("f4b", 24'h000000, 24'h0C0C0C, 24'hFFFFFF, 24'h000000);
`else
        check_lits("f4b", 24'h050505, 24'h0C0C0C, 24'hFFFFFF, 24'h010101);
`endif

        // undersized frame is rejected
        res_q.delete();
        run_frame(3, 50, 0, 1'b0);

        // random FIFO backpressure, stray start while busy
        res_q.delete();
        for (int i = 0; i < 100; i++) res_q.push_back(int'($urandom));
        full_rand = 1'b1;
        run_frame(12, 3000, 20, 1'b0);
        full_rand = 1'b0;

        // reset mid-row aborts the frame
        res_q.delete();
        for (int i = 0; i < 36; i++) res_q.push_back(i * 9 - 100);
        build_frame(8);
        cap_q.delete();
        res_idx  = 0;
        hs       = 1'b0;
        done_cnt = 0;
        start     = 1'b1;
        input_dim = 8'd8;
        @(negedge clock);
        #3;
        start = 1'b0;
        cyc = 0;
        while (res_idx < 5 && cyc < 200) begin
            @(negedge clock);
            #3;
            cyc++;
        end
        check("reached_mid_row", res_idx >= 5, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_wr_en", bus.out_wr_en, 1'b0);
        check("abort_accepting", bus.out_accepting_values, 1'b0);
        check("abort_din", bus.out_din, 24'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clock);
        #3;
        reset = 1'b0;
        exp_q.delete();
        check("no_done_on_abort", done_cnt, 0);
        @(negedge clock);
        #3;

        res_q = '{5, -7, 300, int'(32'h80000000)};
        run_frame(4, 200, 0, 1'b0);
`ifdef CONV_OUT_RELU_EN
        check_lits("f4c", 24'h050505, 24'h000000, 24'hFFFFFF, 24'h000000);
`else
        check_lits("f4c", 24'h050505, 24'h070707, 24'hFFFFFF, 24'hFFFFFF);
`endif

        // full-size frame, resultValid always high
        res_q.delete();
        for (int i = 0; i < 222 * 222; i++) res_q.push_back(int'($urandom));
        run_frame(224, 60000, 0, 1'b0);
        pads = 0;
        for (int i = 0; i < 225 && i < cap_q.size(); i++)
            if (cap_q[i] == PAD_PIXEL) pads++;
        check("n224_leading_pads", pads, 225);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
